// File: rtl/mult_ctrl_pkg.sv
// mult_ctrl_pkg: operand mode encodings, multiplier width selects and controller states.
package mult_ctrl_pkg;

    localparam logic [1:0] MODE_U8  = 2'd0;
    localparam logic [1:0] MODE_S8  = 2'd1;
    localparam logic [1:0] MODE_S16 = 2'd2;
    localparam logic [1:0] MODE_UW  = 2'd3;

    typedef enum logic [1:0] {WSEL_8, WSEL_16, WSEL_FULL} wsel_t;

    typedef enum logic [1:0] {IDLE, FETCH, MULT, DONE} state_t;

    function automatic wsel_t mode_wsel(input logic [1:0] mode);
        case (mode)
            MODE_U8, MODE_S8: return WSEL_8;
            MODE_S16:         return WSEL_16;
            default:          return WSEL_FULL;
        endcase
    endfunction

    function automatic logic mode_signed(input logic [1:0] mode);
        return (mode == MODE_S8) || (mode == MODE_S16);
    endfunction

endpackage

// File: rtl/mult_seq.sv
// mult_seq: radix-2 shift-add multiplier, one multiplier bit per cycle, on operand magnitudes.
// result/finish are combinational views of the step in progress, so the last step's sum is usable on its own edge.
module mult_seq
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  wsel_t              wsel,
    input  logic               is_signed,
    output logic [2*WIDTH-1:0] result,
    output logic               finish
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_next;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [CW-1:0]    count;
    logic [CW-1:0]    n_iter;
    logic             a_neg;
    logic             b_neg;
    logic             neg;

    // Magnitudes are formed as 2^w - x so that -2^(w-1) maps to the exact positive value.
    always_comb begin
        a_neg  = 1'b0;
        b_neg  = 1'b0;
        a_mag  = a;
        b_mag  = b;
        n_iter = CW'(WIDTH);
        case (wsel)
            WSEL_8: begin
                n_iter = CW'(8);
                a_neg  = is_signed & a[7];
                b_neg  = is_signed & b[7];
                a_mag  = a_neg ? WIDTH'(9'h100 - {1'b0, a[7:0]}) : WIDTH'(a[7:0]);
                b_mag  = b_neg ? WIDTH'(9'h100 - {1'b0, b[7:0]}) : WIDTH'(b[7:0]);
            end
            WSEL_16: begin
                n_iter = CW'(16);
                a_neg  = is_signed & a[15];
                b_neg  = is_signed & b[15];
                a_mag  = a_neg ? WIDTH'(17'h10000 - {1'b0, a[15:0]}) : WIDTH'(a[15:0]);
                b_mag  = b_neg ? WIDTH'(17'h10000 - {1'b0, b[15:0]}) : WIDTH'(b[15:0]);
            end
            default: ;
        endcase
    end

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign result   = neg ? -acc_next : acc_next;
    assign finish   = (count == CW'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            neg    <= 1'b0;
        end else if (load) begin
            mcand  <= PW'(a_mag);
            mplier <= b_mag;
            acc    <= '0;
            count  <= n_iter;
            neg    <= a_neg ^ b_neg;
        end else if (count != '0) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
        end
    end

endmodule

// File: rtl/mult_ctrl.sv
// mult_ctrl: operand bank plus a controller that multiplies successive bank pairs via mult_seq.
// Define MULT_CTRL_ACCUM_EN to add the acc/acc_clr running accumulator.
module mult_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               start,
    input  logic [1:0]         mode,
    output logic               busy,
    output logic               valid,
    output logic [2*WIDTH-1:0] product,
    output logic [AW-1:0]      pair_addr
`ifdef MULT_CTRL_ACCUM_EN
    ,
    input  logic               acc_clr,
    output logic [2*WIDTH+7:0] acc
`endif
);
    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0] bank [DEPTH];
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    state_t           state;
    state_t           state_next;
    logic [1:0]       mode_q;
    logic             load;
    logic             seq_finish;
    logic [PW-1:0]    seq_result;

    always_ff @(posedge clock) begin
        if (wr_en) bank[wr_addr] <= wr_data;
    end

    assign op_a = bank[pair_addr];
    assign op_b = bank[pair_addr + AW'(1)];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH: begin
                load       = 1'b1;
                state_next = MULT;
            end
            MULT:    if (seq_finish) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Product is captured on the last iteration's edge, so valid is high exactly during DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q    <= MODE_U8;
            valid     <= 1'b0;
            product   <= '0;
            pair_addr <= '0;
        end else begin
            valid <= 1'b0;
            if (state == IDLE && start) mode_q <= mode;
            if (state == MULT && seq_finish) begin
                valid   <= 1'b1;
                product <= seq_result;
            end
            if (state == DONE)
                pair_addr <= (pair_addr == AW'(DEPTH - 2)) ? '0 : pair_addr + AW'(2);
        end
    end

    mult_seq #(.WIDTH(WIDTH)) u_seq (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .a         (op_a),
        .b         (op_b),
        .wsel      (mode_wsel(mode_q)),
        .is_signed (mode_signed(mode_q)),
        .result    (seq_result),
        .finish    (seq_finish)
    );

`ifdef MULT_CTRL_ACCUM_EN
    logic [PW+7:0] product_ext;

    assign product_ext = mode_signed(mode_q) ? {{8{product[PW-1]}}, product} : {8'd0, product};

    // mode_q is still the in-flight mode during the valid cycle, so it selects the extension.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)       acc <= '0;
        else if (acc_clr) acc <= '0;
        else if (valid)   acc <= acc + product_ext;
    end
`endif

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, maximum operand width in bits; legal values are 16 or greater.
REQ-002 Parameter DEPTH, default 32, number of operand words in the bank; must be even and 2 or greater.
REQ-003 Parameter AW, default $clog2(DEPTH), address width.
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 wr_en  in  1  bank write strobe.
REQ-007 wr_addr  in  AW  bank write address.
REQ-008 wr_data  in  WIDTH  bank write data.
REQ-009 start  in  1  request one multiply of the next operand pair.
REQ-010 mode  in  2  operand mode: 0 = unsigned 8-bit; 1 = signed 8-bit; 2 = signed 16-bit; 3 = unsigned WIDTH-bit.
REQ-011 busy  out  1  high while an operation is in progress (state other than IDLE).
REQ-012 valid  out  1  one-cycle pulse; product is new in this cycle.
REQ-013 product  out  2*WIDTH  result; sign-extended in signed modes, zero-extended otherwise.
REQ-014 pair_addr  out  AW  address of operand A for the next operation.

Function
REQ-015 The bank SHALL be a DEPTH x WIDTH register array with a synchronous write and a combinational read; bank contents are not reset.
REQ-016 FSM states: IDLE, FETCH, MULT, DONE.
- IDLE -> FETCH on start.
- FETCH -> MULT after one cycle.
- MULT -> DONE after N iterations.
- DONE -> IDLE after one cycle.
REQ-017 start SHALL be sampled only in IDLE; start in any other state SHALL be ignored and not queued.
REQ-018 mode SHALL be latched at the edge that accepts start; later changes to mode SHALL not affect the operation in flight.
REQ-019 In FETCH, A SHALL be bank[pair_addr] and B SHALL be bank[pair_addr+1], each truncated to the mode width.
REQ-020 A write to an operand address in the FETCH cycle SHALL not be seen; the pre-write value is used.
REQ-021 N SHALL be 8, 8, 16 or WIDTH for modes 0, 1, 2 and 3 respectively.
REQ-022 Multiplication SHALL use radix-2 shift-add, one bit per cycle.
REQ-023 Signed modes SHALL multiply magnitudes and negate the result if the operand signs differ.
REQ-024 -128*-128 in mode 1 and -32768*-32768 in mode 2 SHALL give the exact positive result.
REQ-025 valid SHALL rise on the (N+2)th rising edge, counting the start-sampling edge as the 1st; product SHALL be updated on that same edge.
REQ-026 product SHALL hold its value until the next valid.
REQ-027 On the DONE edge, pair_addr SHALL advance by 2, wrapping from DEPTH-2 to 0.
REQ-028 start asserted in the DONE cycle SHALL be ignored; back-to-back issue is at best one operation every N+3 cycles.

Reset
REQ-029 Asserting reset (low) SHALL immediately set: state = IDLE, busy = 0, valid = 0, product = 0, pair_addr = 0.
REQ-030 Reset during an operation SHALL abandon it with no valid pulse; the bank SHALL be unaffected.
REQ-031 The first accepted start after reset release SHALL behave normally.

Configuration
REQ-032 With MULT_CTRL_ACCUM_EN defined, the block SHALL add:
- output acc, width 2*WIDTH+8;
- input acc_clr, width 1.
acc SHALL add product, sign-correct in signed modes, on each valid; the addition wraps modulo 2^(2*WIDTH+8).
acc_clr or reset SHALL zero acc; if acc_clr and valid occur together, acc SHALL become 0.
REQ-033 Without MULT_CTRL_ACCUM_EN, neither port nor the accumulator logic SHALL exist.

Structure
REQ-034 Package mult_ctrl_pkg SHALL hold the mode encoding constants and the FSM state enum.
REQ-035 Sub-module mult_seq SHALL implement the iterative multiplier:
- inputs: operands, width select, signed flag, load;
- outputs: result, finish.
mult_ctrl SHALL hold the bank, the FSM, the pointer and the accumulator.

Verification
REQ-036 Mode 0, bank[0] = 0xFF, bank[1] = 0xFF, start -> valid on the 10th edge, product = 0x0000FE01, pair_addr = 2.
REQ-037 Mode 1, 0x80 * 0x02 -> product = 0xFFFFFF00. Mode 1, 0x80 * 0x80 -> product = 0x00004000.
REQ-038 Mode 2, 0x8000 * 0x8000 -> product = 0x40000000, valid on the 18th edge; mode changed to 0 during MULT -> no effect on the result.
REQ-039 DEPTH = 32: 16 operations, then the 17th -> uses addresses 0/1, and pair_addr reads 2 after it.
REQ-040 start held high through an operation -> exactly one valid per accepted start. Reset pulsed mid-MULT -> no valid, all outputs 0, bank retained.
REQ-041 With MULT_CTRL_ACCUM_EN: products 0xFE01 and 0x0001 -> acc = 0xFE02. acc_clr together with valid -> acc = 0.
